// File: rtl/adc_pulse_sampler.sv
// Per-channel ADC capture: skips a programmed number of valid beats after a run
// strobe, averages 2^avg_log2 signed samples, and returns one floor-rounded result.
module adc_pulse_sampler #(
  parameter int NUM_BITS   = 16,
  parameter int DEL_W      = 16,
  parameter int AVG_LOG2_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BITS-1:0]   adc_tdata,
  input  logic                  adc_tvalid,
  input  logic                  run,
  input  logic [DEL_W-1:0]      delay,
  input  logic [AVG_LOG2_W-1:0] avg_log2,
  output logic [NUM_BITS-1:0]   out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err_overlap
);

  localparam int SMP_W = 2 ** AVG_LOG2_W;
  localparam int ACC_W = NUM_BITS + SMP_W - 1;

  typedef enum logic [1:0] {IDLE, SKIP, ACC, OUT} state_t;

  state_t                   state_q;
  logic [DEL_W-1:0]         del_cnt_q;
  logic [AVG_LOG2_W-1:0]    shift_q;
  logic [SMP_W-1:0]         smp_cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [NUM_BITS-1:0]      out_data_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     err_q;

  logic signed [ACC_W-1:0]  adc_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic [NUM_BITS-1:0]      out_data_d;
  logic [SMP_W-1:0]         smp_init;

  // The final beat's sum is formed here so the result registers on that same
  // edge, putting out_valid exactly one cycle after the last accumulated beat.
  always_comb begin
    adc_ext    = '0;
    adc_ext    = {{(ACC_W-NUM_BITS){adc_tdata[NUM_BITS-1]}}, adc_tdata};
    acc_d      = acc_q + adc_ext;
    out_data_d = NUM_BITS'(acc_d >>> shift_q);
    smp_init   = SMP_W'(1) << avg_log2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      del_cnt_q   <= '0;
      shift_q     <= '0;
      smp_cnt_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= run && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (run) begin
            del_cnt_q <= delay;
            shift_q   <= avg_log2;
            smp_cnt_q <= smp_init;
            acc_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= (delay != '0) ? SKIP : ACC;
          end
        end
        SKIP: begin
          if (adc_tvalid) begin
            del_cnt_q <= del_cnt_q - 1'b1;
            if (del_cnt_q == DEL_W'(1)) state_q <= ACC;
          end
        end
        ACC: begin
          if (adc_tvalid) begin
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_q - 1'b1;
            if (smp_cnt_q == SMP_W'(1)) begin
              out_data_q  <= out_data_d;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end
          end
        end
        OUT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign err_overlap = err_q;

endmodule

// File: tb/tb_adc_pulse_sampler.sv
// Self-checking bench for adc_pulse_sampler: table-driven captures scored through
// an expected-result queue, plus hand sequences for overlap, held run and reset abort.
module tb_adc_pulse_sampler;

  logic               clk;
  logic               rst;
  logic [15:0]        adc_tdata;
  logic               adc_tvalid;
  logic               run;
  logic [15:0]        delay;
  logic [2:0]         avg_log2;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               busy;
  logic               err_overlap;

  adc_pulse_sampler #(.NUM_BITS(16), .DEL_W(16), .AVG_LOG2_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_tdata  (adc_tdata),
    .adc_tvalid (adc_tvalid),
    .run        (run),
    .delay      (delay),
    .avg_log2   (avg_log2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .err_overlap(err_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic signed [15:0] exp_q[$];

  typedef struct {
    int                 dly;
    int                 avg;
    int                 base;
    int                 stp;
    int                 gap;
    logic signed [15:0] expv;
  } vec_t;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every out_valid pops one expected result.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      check("sb_nonempty", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
    end
    if (err_overlap) err_cnt++;
  end

  task automatic capture(input int d, input int a, input int base, input int stp,
                         input int gap, input logic signed [15:0] expv);
    int n;
    n = d + (1 << a);
    run = 1'b1; delay = 16'(d); avg_log2 = 3'(a);
    adc_tvalid = 1'b1; adc_tdata = 16'h5A5A;
    exp_q.push_back(expv);
    tick();
    run = 1'b0;
    check("busy_start", busy, 1);
    for (int k = 0; k < n; k++) begin
      if (gap != 0 && k > 0) begin
        adc_tvalid = 1'b0; adc_tdata = 16'($urandom);
        tick();
      end
      adc_tvalid = 1'b1;
      adc_tdata  = 16'(base + stp * k);
      delay      = 16'($urandom);
      avg_log2   = 3'($urandom);
      tick();
    end
    adc_tvalid = 1'b0;
    check("latency_valid", out_valid, 1);
    check("busy_in_out", busy, 1);
    tick();
    check("valid_one_cycle", out_valid, 0);
    check("busy_done", busy, 0);
  endtask

  vec_t vecs[$];
  int   e0;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{3, 0,     10,  1, 0,  16'sd13});
    vecs.push_back('{0, 2,     -3, -1, 0, -16'sd5});
    vecs.push_back('{2, 1,    100, 100, 1, 16'sd350});
    vecs.push_back('{0, 7,  32767,  0, 0,  16'sd32767});
    vecs.push_back('{0, 7, -32768,  0, 0, -16'sd32768});
    vecs.push_back('{5, 3,    -10,  3, 0,  16'sd15});
    vecs.push_back('{1, 1,      7, -2, 1,  16'sd4});
    vecs.push_back('{0, 1,     -1,  0, 0, -16'sd1});
    vecs.push_back('{0, 1,      0, -1, 0, -16'sd1});

    rst = 1'b0; run = 1'b0; adc_tvalid = 1'b0; adc_tdata = '0;
    delay = '0; avg_log2 = '0;
    tick(); tick();
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overlap, 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) capture(vecs[i].dly, vecs[i].avg, vecs[i].base, vecs[i].stp,
                              vecs[i].gap, vecs[i].expv);
    check("no_spurious_err", err_cnt, 0);

    // Overlapping run mid-capture, then back-to-back capture in the dead-cycle slot.
    e0 = err_cnt;
    run = 1'b1; delay = 16'd1; avg_log2 = 3'd1; adc_tvalid = 1'b1; adc_tdata = 16'h1111;
    exp_q.push_back(16'sd23);
    tick();
    run = 1'b1; delay = 16'd0; avg_log2 = 3'd0; adc_tvalid = 1'b0;
    tick();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adc_tvalid = 1'b1; adc_tdata = 16'(20 + 2 * k);
      tick();
    end
    adc_tvalid = 1'b0;
    check("ovl_valid", out_valid, 1);
    tick();
    check("ovl_err_pulses", err_cnt - e0, 1);
    capture(0, 0, 77, 0, 0, 16'sd77);

    // run held for three cycles: accepted once, two overlap pulses.
    e0 = err_cnt;
    run = 1'b1; delay = 16'd0; avg_log2 = 3'd0; adc_tvalid = 1'b0;
    exp_q.push_back(16'sd42);
    tick(); tick(); tick();
    run = 1'b0;
    adc_tvalid = 1'b1; adc_tdata = 16'd42;
    tick();
    adc_tvalid = 1'b0;
    check("held_valid", out_valid, 1);
    tick();
    check("held_err_pulses", err_cnt - e0, 2);

    // Reset during ACC aborts without a result.
    run = 1'b1; delay = 16'd0; avg_log2 = 3'd3; adc_tvalid = 1'b0;
    tick();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adc_tvalid = 1'b1; adc_tdata = 16'd1000;
      tick();
    end
    adc_tvalid = 1'b0;
    check("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("abort_out_data", out_data, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err_overlap, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    check("post_abort_idle_busy", busy, 0);
    capture(1, 0, 5, 1, 0, 16'sd6);

    tick(); tick();
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
